// File: rtl/mesh_router_rr_if.sv
// Packet/handshake bundle for one mesh_router_rr node: upstream side (per-port packet in,
// pending, pop back), downstream side (FIFO heads, pending, pop in) and the drop pulse.
interface mesh_router_rr_if #(
  parameter int PCKG_SZ = 40
);
  logic [4*PCKG_SZ-1:0] data_out_i_in;
  logic [3:0]           pndng_i_in;
  logic [3:0]           popin;
  logic [4*PCKG_SZ-1:0] data_out;
  logic [3:0]           pndng;
  logic [3:0]           pop;
  logic                 err_drop;

  modport slave (
    input  data_out_i_in, pndng_i_in, pop,
    output popin, data_out, pndng, err_drop
  );

  modport master (
    output data_out_i_in, pndng_i_in, pop,
    input  popin, data_out, pndng, err_drop
  );
endinterface

// File: rtl/mesh_router_rr.sv
// 4-port mesh router node: column-first XY routing, round-robin arbiter, per-output FIFOs.
// Optional per-port push counters and drop counter when MESH_ROUTER_PKT_CNT_EN is defined.
module mesh_router_rr #(
  parameter int PCKG_SZ    = 40,
  parameter int FIFO_DEPTH = 4,
  parameter int ID_R       = 1,
  parameter int ID_C       = 1,
  parameter int ROWS       = 4,
  parameter int COLUMS     = 4
) (
  input  logic clk,
  input  logic rst,
`ifdef MESH_ROUTER_PKT_CNT_EN
  output logic [4*16-1:0] pkt_cnt,
  output logic [15:0]     drop_cnt,
`endif
  mesh_router_rr_if.slave rif
);

  if (PCKG_SZ < 16 || FIFO_DEPTH < 2 || ID_R < 1 || ID_R > ROWS ||
      ID_C < 1 || ID_C > COLUMS) begin : g_bad_cfg
    $error("mesh_router_rr: invalid parameter set");
  end

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);
  localparam logic [3:0]    MY_R     = 4'(ID_R);
  localparam logic [3:0]    MY_C     = 4'(ID_C);
  localparam logic [PCKG_SZ-1:0] NJ_MASK = {8'hFF, {(PCKG_SZ-8){1'b0}}};

  typedef enum logic {IDLE, XFER} state_t;

  state_t state, state_nx;
  logic [1:0] rr_ptr;
  logic [1:0] sel, sel_nx;
  logic [1:0] port_q, port_nx;
  logic       drop_q, drop_nx;

  logic [PCKG_SZ-1:0] pkt_in [4];
  logic [PCKG_SZ-1:0] push_pkt;
  logic [3:0]         push, pop_ok;
  logic               drop_now;

  logic [CW-1:0]      cnt    [4];
  logic [PW-1:0]      rd_ptr [4];
  logic [PW-1:0]      wr_ptr [4];
  logic [3:0]         pndng_r;
  logic [PCKG_SZ-1:0] mem    [4][FIFO_DEPTH];

  logic [1:0] cand;
  logic [2:0] rte;
  logic       found;

  // {drop, out_port}: column is resolved first, own coordinates mean drop
  function automatic logic [2:0] route_of(input logic [7:0] hdr);
    logic [3:0] dr, dc;
    dr = hdr[7:4];
    dc = hdr[3:0];
    if (dc > MY_C)      route_of = 3'b001;
    else if (dc < MY_C) route_of = 3'b011;
    else if (dr > MY_R) route_of = 3'b010;
    else if (dr < MY_R) route_of = 3'b000;
    else                route_of = 3'b100;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    ptr_inc = (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    for (int unsigned p = 0; p < 4; p++) begin
      pkt_in[p] = rif.data_out_i_in[p*PCKG_SZ +: PCKG_SZ];
    end
  end

  always_comb begin
    state_nx = state;
    sel_nx   = sel;
    port_nx  = port_q;
    drop_nx  = drop_q;
    found    = 1'b0;
    cand     = '0;
    rte      = '0;
    case (state)
      IDLE: begin
        for (int unsigned i = 1; i <= 4; i++) begin
          cand = rr_ptr + 2'(i);
          rte  = route_of(pkt_in[cand][PCKG_SZ-9 -: 8]);
          if (!found && rif.pndng_i_in[cand] && (rte[2] || cnt[rte[1:0]] < FULL_CNT)) begin
            found   = 1'b1;
            sel_nx  = cand;
            port_nx = rte[1:0];
            drop_nx = rte[2];
          end
        end
        if (found) state_nx = XFER;
      end
      XFER:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= 2'd3;
      sel    <= '0;
      port_q <= '0;
      drop_q <= 1'b0;
    end else begin
      state  <= state_nx;
      sel    <= sel_nx;
      port_q <= port_nx;
      drop_q <= drop_nx;
      if (state == XFER) rr_ptr <= sel;
    end
  end

  assign rif.popin    = (state == XFER) ? (4'b0001 << sel) : 4'b0000;
  assign drop_now     = (state == XFER) && drop_q;
  assign rif.err_drop = drop_now;
  assign push_pkt     = (pkt_in[sel] & ~NJ_MASK) | (PCKG_SZ'(port_q) << (PCKG_SZ - 8));

  always_comb begin
    for (int unsigned q = 0; q < 4; q++) begin
      push[q]   = (state == XFER) && !drop_q && (port_q == 2'(q));
      pop_ok[q] = rif.pop[q] && (cnt[q] != '0);
      rif.data_out[q*PCKG_SZ +: PCKG_SZ] = (cnt[q] != '0) ? mem[q][rd_ptr[q]] : '0;
    end
  end

  assign rif.pndng = pndng_r;

  // pndng follows the count one cycle later, giving the select/xfer/count latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pndng_r <= '0;
      for (int unsigned q = 0; q < 4; q++) begin
        cnt[q]    <= '0;
        rd_ptr[q] <= '0;
        wr_ptr[q] <= '0;
      end
    end else begin
      for (int unsigned q = 0; q < 4; q++) begin
        pndng_r[q] <= (cnt[q] != '0);
        if (push[q])   wr_ptr[q] <= ptr_inc(wr_ptr[q]);
        if (pop_ok[q]) rd_ptr[q] <= ptr_inc(rd_ptr[q]);
        case ({push[q], pop_ok[q]})
          2'b10:   cnt[q] <= cnt[q] + 1'b1;
          2'b01:   cnt[q] <= cnt[q] - 1'b1;
          default: cnt[q] <= cnt[q];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned q = 0; q < 4; q++) begin
      if (push[q]) mem[q][wr_ptr[q]] <= push_pkt;
    end
  end

`ifdef MESH_ROUTER_PKT_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      for (int unsigned q = 0; q < 4; q++) begin
        if (push[q]) pkt_cnt[q*16 +: 16] <= pkt_cnt[q*16 +: 16] + 16'd1;
      end
      if (drop_now) drop_cnt <= drop_cnt + 16'd1;
    end
  end
`else
`endif

endmodule

// File: doc/mesh_router_rr.md
Name: mesh_router_rr

Overview:
- Parametrised successor to the single-cycle mesh router emulator: one 4-port mesh router node (N/E/S/W) with column-first XY routing and round-robin arbitration.
- Per-output FIFOs of configurable depth; an input is granted only when its target FIFO has space.
- Instantiated ROWS x COLUMS times inside the mesh emulator; edge ports connect to terminals.

Parameters:
- PCKG_SZ, 40, packet width in bits (min 16).
- FIFO_DEPTH, 4, entries per output FIFO (min 2).
- ID_R, 1, router row, 1..ROWS.
- ID_C, 1, router column, 1..COLUMS.
- ROWS, 4, mesh rows (informational; terminals at rows 0 and ROWS+1).
- COLUMS, 4, mesh columns (terminals at columns 0 and COLUMS+1).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- data_out_i_in  in  4*PCKG_SZ  input packet per port; slice p = [p*PCKG_SZ +: PCKG_SZ]
- pndng_i_in  in  4  upstream has a packet on port p
- popin  out  4  one-cycle pop to upstream p
- data_out  out  4*PCKG_SZ  head of output FIFO p (show-ahead)
- pndng  out  4  output FIFO p non-empty
- pop  in  4  downstream consumes the head of FIFO p
- err_drop  out  1  one-cycle pulse when a packet is dropped

Port indices: 0=north (row-1), 1=east (col+1), 2=south (row+1), 3=west (col-1).

Behaviour:
- Header fields:
  - dst_r = pkt[PCKG_SZ-9 -: 4]
  - dst_c = pkt[PCKG_SZ-13 -: 4]
  - next-jump field = pkt[PCKG_SZ-1 -: 8]
- Route, column-first: dst_c>ID_C -> east; dst_c<ID_C -> west; else dst_r>ID_R -> south; dst_r<ID_R -> north; else (own coords) -> drop.
- Stored packet: next-jump field overwritten with 8'(out_port); all other bits unchanged.
- Arbiter FSM:
  - IDLE: scan inputs starting at rr_ptr+1 mod 4. Pick the first p with pndng_i_in[p]=1 whose target FIFO count<FIFO_DEPTH, or whose route is a drop. Latch p and its route; go to XFER. If nothing qualifies, stay in IDLE.
  - XFER: popin[p]=1 for exactly this cycle. At the clock edge, push the rewritten packet into the target FIFO (or pulse err_drop=1 for this cycle on a drop). Set rr_ptr=p; return to IDLE.
- Throughput and latency:
  - At most one transfer every 2 cycles.
  - Latency from pndng_i_in rise to pndng rise on the target port is 3 cycles: IDLE select, XFER, registered count.
- Upstream must hold data and pndng stable until it sees popin.
- Data is sampled during XFER. Data changes between IDLE and XFER are undefined; no check.
- Output FIFOs:
  - pndng[q] = (count_q != 0), registered.
  - data_out[q] = head entry; zero when empty.
  - pop[q] while empty is ignored; count never underflows.
  - Push and pop on the same FIFO in one cycle: both take effect, count unchanged.
  - Full is judged from the count registered at IDLE selection. A same-cycle pop never causes overflow; a full FIFO is never pushed.
  - Pointers wrap modulo FIFO_DEPTH.
- Blocked input: an input whose target FIFO is full is skipped. Other inputs continue to be served (no head-of-line blocking across inputs).
- Reset (any time, including mid-XFER):
  - FSM to IDLE; rr_ptr=3, so port 0 has first priority.
  - All FIFOs emptied.
  - popin=0, pndng=0, data_out=0, err_drop=0.
  - An in-flight packet is neither pushed nor popped.

Optional Feature:
- Macro: MESH_ROUTER_PKT_CNT_EN.
- Defined:
  - Adds output port pkt_cnt (4*16 bits), one 16-bit counter per output port.
  - Each counter increments on every push to its FIFO and wraps from 0xFFFF to 0.
  - Adds output drop_cnt (16 bits), incremented with each err_drop pulse.
  - All counters cleared by rst.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Router ID_R=2, ID_C=2; west input pkt dst_r=2, dst_c=5 -> popin[3] one cycle; 3 cycles later pndng[1]=1, data_out[1][39:32]=8'd1, payload bits intact.
- All 4 inputs pending simultaneously, destinations in distinct FIFOs, after reset -> grants in order 0,1,2,3, one every 2 cycles; 4 popin pulses total.
- FIFO_DEPTH=4, east FIFO never popped, 6 east-bound packets from north -> 4 accepted, pndng_i_in[0] stays high with no popin. A south-bound packet on port 2 is still granted. One pop[1] -> the 5th east-bound packet is accepted.
- Packet with dst_r=ID_R, dst_c=ID_C on port 1 -> popin[1] pulse and err_drop pulse; no FIFO changes.
- pop[2] while FIFO 2 is empty -> no state change; push and pop on a FIFO holding 1 entry in the same cycle -> count stays 1, head becomes the new packet.
- Assert rst during XFER -> popin drops immediately; all pndng=0; after release, port 0 wins first arbitration.
